// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator front end.
//   - db_state_t : button debouncer FSM states
//   - KEY_*      : operator / clear key codes
//   - KEYMAP     : 4x4 keypad layout, row-major from the top-left cell.
//                  The same table drives clickedSquare and the VGA painter.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } db_state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // Index is {row, col}; element 0 is the top-left cell.
  localparam logic [0:15][3:0] KEYMAP = '{
    4'h7,    4'h8, 4'h9,   KEY_DIV,
    4'h4,    4'h5, 4'h6,   KEY_MUL,
    4'h1,    4'h2, 4'h3,   KEY_SUB,
    KEY_CLR, 4'h0, KEY_EQ, KEY_ADD
  };

  function automatic logic [3:0] keymap_lookup(input logic [1:0] row,
                                               input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: synchronizes and debounces one raw mouse button.
// Ports:
//   clk            - system clock
//   reset          - asynchronous active-low reset
//   btn_raw        - raw button level (asynchronous)
//   press_accepted - one-cycle strobe, high in the cycle in which the FSM
//                    moves PRESS_DB -> HELD (combinational, not registered)
//   state          - current FSM state, exposed for debug/observation
// Strobe semantics: press_accepted has no ready; the consumer must capture
// whatever it needs in the same clock edge that ends the strobe cycle.
module btn_debouncer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      btn_raw,
  output logic      press_accepted,
  output db_state_t state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync_q1, sync_q2;
  logic            sync;
  db_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;

  assign sync  = sync_q2;
  assign state = state_q;

  // Counter stops at CNT_LAST rather than wrapping.
  assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Reset lands in REL_DB so a button held through reset must be released
  // and debounced before any new press can count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= REL_DB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    press_accepted = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = HELD;
          press_accepted = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end
      end
      REL_DB: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = REL_DB;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/click_event_decoder.sv
// click_event_decoder: turns debounced left-button clicks on the on-screen
// 4x4 keypad into key events.
// Ports:
//   clk       - system clock (CLK25 domain)
//   reset     - asynchronous active-low reset
//   btn[2:0]  - raw mouse buttons; only btn[0] (left) is used
//   xm, ym    - pointer position in pixels
//   key_code  - code of the last accepted key, held until the next event
//   new_digit - one-cycle pulse, key_code is 0-9
//   new_op    - one-cycle pulse, key_code is A-E
//   clear     - one-cycle pulse, key_code is F
// The pointer is sampled on the accepting edge, registered into a hit stage,
// and the outputs are registered one edge later.
module click_event_decoder
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRID_X0         = 160,
  parameter int GRID_Y0         = 80,
  parameter int CELL_W          = 80,
  parameter int CELL_H          = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic [9:0] xm,
  input  logic [8:0] ym,
  output logic [3:0] key_code,
  output logic       new_digit,
  output logic       new_op,
  output logic       clear
);

  localparam logic [31:0] X0 = 32'(GRID_X0);
  localparam logic [31:0] X1 = 32'(GRID_X0 + CELL_W);
  localparam logic [31:0] X2 = 32'(GRID_X0 + 2 * CELL_W);
  localparam logic [31:0] X3 = 32'(GRID_X0 + 3 * CELL_W);
  localparam logic [31:0] X4 = 32'(GRID_X0 + 4 * CELL_W);
  localparam logic [31:0] Y0 = 32'(GRID_Y0);
  localparam logic [31:0] Y1 = 32'(GRID_Y0 + CELL_H);
  localparam logic [31:0] Y2 = 32'(GRID_Y0 + 2 * CELL_H);
  localparam logic [31:0] Y3 = 32'(GRID_Y0 + 3 * CELL_H);
  localparam logic [31:0] Y4 = 32'(GRID_Y0 + 4 * CELL_H);

  logic        accept;
  db_state_t   dbg_state_unused;
  logic        unused_btn;
  logic [31:0] x_ext, y_ext;
  logic [1:0]  col, row;
  logic        in_grid;
  logic [3:0]  hit_code;
  logic        hit_vld_q;
  logic [3:0]  hit_code_q;

  // Right and middle buttons are intentionally not decoded.
  assign unused_btn = ^btn[2:1];

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn[0]),
    .press_accepted(accept),
    .state         (dbg_state_unused)
  );

  assign x_ext = 32'(xm);
  assign y_ext = 32'(ym);

  // Cell index from a comparator ladder; the result is only meaningful
  // when in_grid is set.
  always_comb begin
    col = 2'd3;
    if (x_ext < X1)      col = 2'd0;
    else if (x_ext < X2) col = 2'd1;
    else if (x_ext < X3) col = 2'd2;

    row = 2'd3;
    if (y_ext < Y1)      row = 2'd0;
    else if (y_ext < Y2) row = 2'd1;
    else if (y_ext < Y3) row = 2'd2;

    in_grid  = (x_ext >= X0) && (x_ext < X4) && (y_ext >= Y0) && (y_ext < Y4);
    hit_code = keymap_lookup(row, col);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_vld_q  <= 1'b0;
      hit_code_q <= 4'h0;
    end else begin
      hit_vld_q <= accept && in_grid;
      if (accept) hit_code_q <= hit_code;
    end
  end

  // Misses never reach here, so key_code keeps the previous key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= 4'h0;
      new_digit <= 1'b0;
      new_op    <= 1'b0;
      clear     <= 1'b0;
    end else begin
      new_digit <= 1'b0;
      new_op    <= 1'b0;
      clear     <= 1'b0;
      if (hit_vld_q) begin
        key_code  <= hit_code_q;
        new_digit <= (hit_code_q <= 4'h9);
        new_op    <= (hit_code_q >= KEY_ADD) && (hit_code_q <= KEY_EQ);
        clear     <= (hit_code_q == KEY_CLR);
      end
    end
  end

endmodule

// File: tb/tb_click_event_decoder.sv
module tb_click_event_decoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn = 3'b000;
  logic [9:0] xm = 10'd0;
  logic [8:0] ym = 9'd0;
  logic [3:0] key_code;
  logic       new_digit, new_op, clear;

  click_event_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .xm       (xm),
    .ym       (ym),
    .key_code (key_code),
    .new_digit(new_digit),
    .new_op   (new_op),
    .clear    (clear)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Keypad as drawn on screen, row-major from the top-left.
  int kp[16] = '{7, 8, 9, 13, 4, 5, 6, 12, 1, 2, 3, 11, 15, 0, 14, 10};

  logic       m_r1, m_r2;     // two-sample delay of the raw button
  logic       m_acc;          // level currently accepted by the debouncer
  int         m_run;          // consecutive samples disagreeing with m_acc
  logic       m_stage_vld;
  logic [3:0] m_stage_code;
  logic [3:0] m_key;
  logic       m_dig, m_op, m_clr;

  // Scoreboard: {digit, op, clear, code} of each event the model predicts.
  logic [6:0] exp_q[$];

  int         pulse_cnt;
  logic [2:0] last_pulse;
  logic       step_pulse;

  function automatic int ref_code(input int x, input int y);
    if (x < 160 || x >= 480 || y < 80 || y >= 400) return -1;
    return kp[((y - 80) / 80) * 4 + (x - 160) / 80];
  endfunction

  task automatic model_reset();
    m_r1 = 1'b0; m_r2 = 1'b0;
    m_acc = 1'b1;           // a release must be seen first
    m_run = 1;              // the reset cycle already counts as one release sample
    m_stage_vld = 1'b0; m_stage_code = 4'h0;
    m_key = 4'h0; m_dig = 1'b0; m_op = 1'b0; m_clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic s;
    int   code;
    m_dig = m_stage_vld && (m_stage_code <= 4'd9);
    m_op  = m_stage_vld && (m_stage_code >= 4'd10) && (m_stage_code <= 4'd14);
    m_clr = m_stage_vld && (m_stage_code == 4'd15);
    if (m_stage_vld) begin
      m_key = m_stage_code;
      exp_q.push_back({m_dig, m_op, m_clr, m_stage_code});
    end
    s = m_r2; m_r2 = m_r1; m_r1 = btn[0];
    if (s != m_acc) m_run++;
    else m_run = 0;
    m_stage_vld = 1'b0;
    // A level change is accepted after D+1 consecutive agreeing samples.
    if (m_run == D + 1) begin
      m_acc = s;
      m_run = 0;
      if (s) begin
        code = ref_code(int'(xm), int'(ym));
        if (code >= 0) begin
          m_stage_vld  = 1'b1;
          m_stage_code = 4'(code);
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called with clk low; returns at the next falling edge.
  task automatic step(input logic b0, input logic [1:0] bhi, input int x, input int y);
    btn = {bhi, b0};
    xm  = 10'(x);
    ym  = 9'(y);
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check("outputs", {28'd0, key_code}, {28'd0, m_key});
    check("pulses", {29'd0, new_digit, new_op, clear}, {29'd0, m_dig, m_op, m_clr});
    step_pulse = new_digit | new_op | clear;
    if (step_pulse) begin
      pulse_cnt++;
      last_pulse = {new_digit, new_op, clear};
      if (exp_q.size() == 0) check("unexpected_event", 32'd1, 32'd0);
      else check("event", {25'd0, new_digit, new_op, clear, key_code}, {25'd0, exp_q.pop_front()});
    end
  endtask

  task automatic do_reset(input logic b0);
    btn = {2'b00, b0};
    reset = 1'b0;
    #1;
    check("reset_outputs", {28'd0, key_code, new_digit, new_op, clear}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic click(input int x, input int y, input logic [1:0] bhi);
    pulse_cnt = 0; last_pulse = 3'b000;
    repeat (D + 8) step(1'b1, bhi, x, y);
    repeat (D + 8) step(1'b0, bhi, x, y);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         x;
    int         y;
    logic [1:0] bhi;
    logic [3:0] exp_key;
    logic [2:0] exp_pulse;   // {digit, op, clear}
  } vec_t;

  vec_t vecs[12];

  initial begin
    int first_pulse;
    int len;
    logic lvl;
    int rx, ry;
    logic [1:0] rb;

    vecs[0]  = '{x: 170, y:  90, bhi: 2'b00, exp_key: 4'h7, exp_pulse: 3'b100};
    vecs[1]  = '{x: 479, y: 399, bhi: 2'b00, exp_key: 4'hA, exp_pulse: 3'b010};
    vecs[2]  = '{x: 480, y: 399, bhi: 2'b00, exp_key: 4'hA, exp_pulse: 3'b000};
    vecs[3]  = '{x: 250, y: 330, bhi: 2'b11, exp_key: 4'h0, exp_pulse: 3'b100};
    vecs[4]  = '{x: 170, y: 330, bhi: 2'b00, exp_key: 4'hF, exp_pulse: 3'b001};
    vecs[5]  = '{x: 400, y:  90, bhi: 2'b10, exp_key: 4'hD, exp_pulse: 3'b010};
    vecs[6]  = '{x: 330, y: 250, bhi: 2'b00, exp_key: 4'h3, exp_pulse: 3'b100};
    vecs[7]  = '{x: 159, y: 200, bhi: 2'b00, exp_key: 4'h3, exp_pulse: 3'b000};
    vecs[8]  = '{x: 400, y: 170, bhi: 2'b01, exp_key: 4'hC, exp_pulse: 3'b010};
    vecs[9]  = '{x: 240, y: 399, bhi: 2'b00, exp_key: 4'h0, exp_pulse: 3'b100};
    vecs[10] = '{x: 160, y:  80, bhi: 2'b00, exp_key: 4'h7, exp_pulse: 3'b100};
    vecs[11] = '{x: 300, y:  79, bhi: 2'b00, exp_key: 4'h7, exp_pulse: 3'b000};

    pulse_cnt = 0; last_pulse = 3'b000; step_pulse = 1'b0;
    model_reset();
    #2;
    do_reset(1'b0);

    // Latency: release 5 cycles, then press; pulse expected after edge D+3.
    repeat (5) step(1'b0, 2'b00, 170, 90);
    pulse_cnt = 0; first_pulse = -1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 2'b00, 170, 90);
      if (step_pulse && first_pulse < 0) first_pulse = k;
    end
    check("latency_edge", 32'(first_pulse), 32'(D + 3));
    check("latency_kind", {29'd0, last_pulse}, 32'b100);
    check("latency_key", {28'd0, key_code}, 32'h7);
    repeat (8) step(1'b0, 2'b00, 170, 90);
    check("latency_single", 32'(pulse_cnt), 32'd1);

    // Table of single clicks.
    for (int i = 0; i < 12; i++) begin
      click(vecs[i].x, vecs[i].y, vecs[i].bhi);
      check($sformatf("vec%0d_count", i), 32'(pulse_cnt), (vecs[i].exp_pulse != 3'b000) ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_kind", i), {29'd0, last_pulse}, {29'd0, vecs[i].exp_pulse});
      check($sformatf("vec%0d_key", i), {28'd0, key_code}, {28'd0, vecs[i].exp_key});
    end

    // Press glitch: 3 high, 3 low, 3 high never reaches D+1 stable samples.
    pulse_cnt = 0;
    repeat (3) step(1'b1, 2'b00, 250, 330);
    repeat (3) step(1'b0, 2'b00, 250, 330);
    repeat (3) step(1'b1, 2'b00, 250, 330);
    repeat (10) step(1'b0, 2'b00, 250, 330);
    check("glitch_none", 32'(pulse_cnt), 32'd0);
    check("glitch_key", {28'd0, key_code}, 32'h7);

    // Drag while held: one clear event only.
    pulse_cnt = 0;
    repeat (12) step(1'b1, 2'b00, 170, 330);
    repeat (12) step(1'b1, 2'b00, 400, 90);
    repeat (12) step(1'b0, 2'b00, 400, 90);
    check("drag_count", 32'(pulse_cnt), 32'd1);
    check("drag_kind", {29'd0, last_pulse}, 32'b001);
    check("drag_key", {28'd0, key_code}, 32'hF);

    // Reset during HELD with the button still down.
    pulse_cnt = 0;
    repeat (12) step(1'b1, 2'b00, 250, 170);
    check("pre_reset_key", {28'd0, key_code}, 32'h5);
    do_reset(1'b1);
    pulse_cnt = 0;
    repeat (15) step(1'b1, 2'b00, 250, 170);
    check("held_reset_none", 32'(pulse_cnt), 32'd0);
    check("held_reset_key", {28'd0, key_code}, 32'h0);
    repeat (8) step(1'b0, 2'b00, 250, 170);
    click(400, 90, 2'b00);
    check("post_reset_count", 32'(pulse_cnt), 32'd1);
    check("post_reset_key", {28'd0, key_code}, 32'hD);

    // Long hold with a short release glitch: still one event.
    pulse_cnt = 0;
    repeat (40) step(1'b1, 2'b00, 330, 250);
    repeat (2) step(1'b0, 2'b00, 330, 250);
    repeat (20) step(1'b1, 2'b00, 330, 250);
    repeat (12) step(1'b0, 2'b00, 330, 250);
    check("hold_glitch_count", 32'(pulse_cnt), 32'd1);
    check("hold_glitch_key", {28'd0, key_code}, 32'h3);

    // Random runs against the model.
    rx = 200; ry = 200;
    for (int i = 0; i < 80; i++) begin
      len = $urandom_range(1, 9);
      lvl = 1'($urandom_range(0, 1));
      rb  = 2'($urandom_range(0, 3));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          rx = $urandom_range(140, 500);
          ry = $urandom_range(60, 420);
        end
        step(lvl, rb, rx, ry);
      end
      if (i == 40) do_reset(lvl);
    end
    repeat (12) step(1'b0, 2'b00, rx, ry);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time guard.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
